// File: rtl/pattern_pkg.sv
// Shared types and helpers for the serial pattern generator/detector pair.
// Latency: n/a (package). Backpressure: n/a.
// Holds the FSM encoding, default widths and the two-ones window test.
package pattern_pkg;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_COUNT_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } gen_state_t;

    // True for 011, 101 and 110: even parity rules out odd counts, nonzero rules out 000.
    function automatic logic is_pattern(input logic [2:0] w);
        return (^w == 1'b0) && (w != 3'b000);
    endfunction

endpackage

// File: rtl/pattern_window_counter.sv
// 3-bit history of driven serial bits plus a saturating count of two-ones windows.
// Latency: count reflects a bit on the same edge the bit is driven.
// Backpressure: none; samples only when bit_vld is high.
module pattern_window_counter
    import pattern_pkg::*;
#(
    parameter int COUNT_W = DEF_COUNT_W
) (
    input  logic               clk,
    input  logic               rstb,
    input  logic               bit_dat,
    input  logic               bit_vld,
    input  logic               clear,
    output logic [COUNT_W-1:0] match_count
);

    logic [2:0] hist;
    logic [2:0] window;

    // Newest bit enters at the MSB, matching the detector's window orientation.
    assign window = {bit_dat, hist[2:1]};

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            hist        <= 3'b000;
            match_count <= '0;
        end else begin
            if (bit_vld) begin
                hist <= window;
            end
            if (clear) begin
                match_count <= '0;
            end else if (bit_vld && is_pattern(window) && (match_count != '1)) begin
                match_count <= match_count + COUNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/pattern_generator.sv
// Serializes valid/ready words LSB-first onto serial_pattern and counts two-ones windows sent.
// Latency: word accepted at edge N from idle drives bit0 after edge N+1, last bit after N+DATA_W.
// Backpressure: in_ready low while the 1-entry holding register is full.
module pattern_generator
    import pattern_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int GAP_CYCLES = 0,
    parameter int COUNT_W    = DEF_COUNT_W
) (
    input  logic               clk,
    input  logic               rstb,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               serial_pattern,
    output logic               enable,
    output logic               busy,
    input  logic               clear_count,
    output logic [COUNT_W-1:0] match_count
);

    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    gen_state_t        state;
    logic [DATA_W-1:0] hold_dat;
    logic              hold_full;
    logic [DATA_W-1:0] shift_dat;
    logic [BIT_W-1:0]  bit_cnt;
    logic [GAP_W-1:0]  gap_cnt;

    logic              accept;
    logic              next_avail;
    logic [DATA_W-1:0] next_word;
    logic              last_bit;
    logic              gap_done;
    logic              load;

    assign in_ready   = !hold_full;
    assign accept     = in_valid && in_ready;
    assign next_avail = hold_full || accept;
    // An empty holding register lets a same-cycle accept bypass straight into the shifter.
    assign next_word  = hold_full ? hold_dat : in_data;
    assign last_bit   = (state == SHIFT) && (bit_cnt == BIT_W'(DATA_W - 1));
    assign gap_done   = (state == GAP) && (gap_cnt == GAP_W'(GAP_CYCLES - 1));
    assign load       = next_avail && ((state == IDLE) || gap_done ||
                                       (last_bit && (GAP_CYCLES == 0)));
    assign busy       = (state != IDLE) || hold_full;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state          <= IDLE;
            hold_dat       <= '0;
            hold_full      <= 1'b0;
            shift_dat      <= '0;
            bit_cnt        <= '0;
            gap_cnt        <= '0;
            serial_pattern <= 1'b0;
            enable         <= 1'b0;
        end else begin
            if (hold_full) begin
                hold_full <= !load;
            end else if (accept && !load) begin
                hold_full <= 1'b1;
                hold_dat  <= in_data;
            end

            case (state)
                IDLE: begin
                    serial_pattern <= 1'b0;
                    enable         <= 1'b0;
                    if (load) begin
                        shift_dat <= next_word;
                        bit_cnt   <= '0;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    serial_pattern <= shift_dat[0];
                    enable         <= 1'b1;
                    shift_dat      <= shift_dat >> 1;
                    bit_cnt        <= bit_cnt + BIT_W'(1);
                    if (last_bit) begin
                        bit_cnt <= '0;
                        gap_cnt <= '0;
                        if (GAP_CYCLES > 0) begin
                            state <= GAP;
                        end else if (load) begin
                            shift_dat <= next_word;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                GAP: begin
                    serial_pattern <= 1'b0;
                    enable         <= 1'b0;
                    gap_cnt        <= gap_cnt + GAP_W'(1);
                    if (gap_done) begin
                        if (load) begin
                            shift_dat <= next_word;
                            state     <= SHIFT;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    pattern_window_counter #(
        .COUNT_W (COUNT_W)
    ) u_window_counter (
        .clk         (clk),
        .rstb        (rstb),
        .bit_dat     (shift_dat[0]),
        .bit_vld     (state == SHIFT),
        .clear       (clear_count),
        .match_count (match_count)
    );

endmodule

// File: tb/tb_pattern_generator.sv
// Bench for pattern_generator: two instances (no gap / 4-bit counter, and 2-cycle gap / 16-bit counter)
// checked every cycle against a transmitted-bit queue and a last-three-bits window model.
module tb_pattern_generator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstb;
    logic [7:0]  in_data  [2];
    logic        in_valid [2];
    logic        in_ready [2];
    logic        serial_w [2];
    logic        enable_w [2];
    logic        busy_w   [2];
    logic        clear_w  [2];
    logic [15:0] mc_w     [2];
    logic [3:0]  mc0;
    logic [15:0] mc1;

    assign mc_w[0] = {12'h000, mc0};
    assign mc_w[1] = mc1;

    pattern_generator #(.DATA_W(8), .GAP_CYCLES(0), .COUNT_W(4)) dut0 (
        .clk(clk), .rstb(rstb), .in_data(in_data[0]), .in_valid(in_valid[0]),
        .in_ready(in_ready[0]), .serial_pattern(serial_w[0]), .enable(enable_w[0]),
        .busy(busy_w[0]), .clear_count(clear_w[0]), .match_count(mc0));

    pattern_generator #(.DATA_W(8), .GAP_CYCLES(2), .COUNT_W(16)) dut1 (
        .clk(clk), .rstb(rstb), .in_data(in_data[1]), .in_valid(in_valid[1]),
        .in_ready(in_ready[1]), .serial_pattern(serial_w[1]), .enable(enable_w[1]),
        .busy(busy_w[1]), .clear_count(clear_w[1]), .match_count(mc1));

    int compared   = 0;
    int mismatched = 0;

    bit exp_q0[$];
    bit exp_q1[$];
    bit sent0[$];
    bit sent1[$];
    int mcount[2];
    bit clr_s[2];
    int run0, max_run0, bits0;
    int ends0[$];

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: every enabled bit must be the next queued bit; count windows of the last
    // three transmitted bits (zeros before the first) holding exactly two ones.
    task automatic check_inst(input int g);
        bit q[$];
        bit s[$];
        bit en, sp, e;
        int mc, ones, n, lim, pending;
        en  = enable_w[g];
        sp  = serial_w[g];
        mc  = int'(mc_w[g]);
        lim = (g == 0) ? 15 : 65535;
        if (!rstb) begin
            if (g == 0) begin exp_q0.delete(); sent0.delete(); end
            else        begin exp_q1.delete(); sent1.delete(); end
            mcount[g] = 0;
            check("reset_enable", int'(en), 0);
            check("reset_count", mc, 0);
            return;
        end
        if (g == 0) begin q = exp_q0; s = sent0; end
        else        begin q = exp_q1; s = sent1; end
        ones = 0;
        if (!en) begin
            check("idle_serial_zero", int'(sp), 0);
        end else begin
            pending = q.size();
            compared++;
            if (pending == 0) begin
                mismatched++;
                $display("FAIL unexpected_bit: inst %0d enable=%0d with %0d bits pending (t=%0t)",
                         g, en, pending, $time);
            end else begin
                e = q.pop_front();
                check("serial_bit", int'(sp), int'(e));
                s.push_back(e);
                if (s.size() > 3) void'(s.pop_front());
                n = s.size();
                ones = int'(s[n-1]) + ((n > 1) ? int'(s[n-2]) : 0) + ((n > 2) ? int'(s[n-3]) : 0);
            end
        end
        if (clr_s[g]) mcount[g] = 0;
        else if (ones == 2 && mcount[g] < lim) mcount[g]++;
        check("match_count", mc, mcount[g]);
        if (g == 0) begin
            exp_q0 = q; sent0 = s;
            if (en) begin
                run0++;
                bits0++;
                if (bits0 % 8 == 0) ends0.push_back(mc);
            end else begin
                run0 = 0;
            end
            if (run0 > max_run0) max_run0 = run0;
        end else begin
            exp_q1 = q; sent1 = s;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            clr_s[0] = clear_w[0];
            clr_s[1] = clear_w[1];
            @(negedge clk);
            check_inst(0);
            check_inst(1);
        end
    end

    task automatic do_reset();
        #1 rstb = 1'b0;
        repeat (2) @(posedge clk);
        #2 rstb = 1'b1;
        @(negedge clk);
    endtask

    task automatic send_word(input int g, input logic [7:0] d);
        bit rdy;
        bit done = 1'b0;
        in_data[g]  = d;
        in_valid[g] = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            rdy = in_ready[g];
            @(posedge clk);
            if (rdy) begin
                done = 1'b1;
                for (int b = 0; b < 8; b++) begin
                    if (g == 0) exp_q0.push_back(d[b]);
                    else        exp_q1.push_back(d[b]);
                end
            end else begin
                @(negedge clk);
            end
        end
        check("accept", int'(done), 1);
        @(negedge clk);
        in_valid[g] = 1'b0;
    endtask

    task automatic wait_idle(input int g);
        bit ok = 1'b0;
        int qs;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            qs = (g == 0) ? exp_q0.size() : exp_q1.size();
            if (!busy_w[g] && qs == 0) ok = 1'b1;
        end
        check("drain", int'(ok), 1);
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        int exp_ends[6];
        int ones, zeros, ens;
        bit seen_next;
        exp_ends = '{3, 7, 11, 15, 15, 15};
        rstb = 1'b0;
        for (int g = 0; g < 2; g++) begin
            in_data[g] = 8'h00; in_valid[g] = 1'b0; clear_w[g] = 1'b0;
            clr_s[g] = 1'b0; mcount[g] = 0;
        end
        run0 = 0; max_run0 = 0; bits0 = 0;

        @(negedge clk);
        do_reset();
        check("rst_enable", int'(enable_w[0]), 0);
        check("rst_serial", int'(serial_w[0]), 0);
        check("rst_in_ready", int'(in_ready[0]), 1);
        check("rst_busy", int'(busy_w[0]), 0);
        check("rst_count", int'(mc_w[0]), 0);

        // All-zero word: eight enabled zero bits, no matches.
        max_run0 = 0;
        send_word(0, 8'h00);
        wait_idle(0);
        check("zero_word_run", max_run0, 8);
        check("zero_word_count", int'(mc_w[0]), 0);
        check("zero_word_ready", int'(in_ready[0]), 1);
        check("zero_word_busy", int'(busy_w[0]), 0);

        // 8'h03: first-bit latency and windows 110, 011.
        do_reset();
        send_word(0, 8'h03);
        check("lat_before_bit0", int'(enable_w[0]), 0);
        @(negedge clk);
        check("lat_bit0_enable", int'(enable_w[0]), 1);
        check("lat_bit0_value", int'(serial_w[0]), 1);
        wait_idle(0);
        check("word03_count", int'(mc_w[0]), 2);

        do_reset();
        send_word(0, 8'h55);
        wait_idle(0);
        check("word55_count", int'(mc_w[0]), 3);

        // Six back-to-back words; the source holds in_valid while in_ready is low.
        do_reset();
        bits0 = 0; ends0.delete(); max_run0 = 0;
        repeat (6) send_word(0, 8'h55);
        wait_idle(0);
        check("b2b_run", max_run0, 48);
        check("b2b_words", ends0.size(), 6);
        for (int i = 0; i < 6 && i < ends0.size(); i++) check("b2b_word_end_count", ends0[i], exp_ends[i]);
        check("b2b_saturated", int'(mc_w[0]), 15);

        // Gap instance: second word held while first shifts, history crosses the gap.
        do_reset();
        send_word(1, 8'h55);
        send_word(1, 8'h55);
        check("gap_hold_ready", int'(in_ready[1]), 0);
        ones = 0; zeros = 0; seen_next = 1'b0;
        for (int i = 0; i < 100 && !seen_next; i++) begin
            if (enable_w[1]) begin
                if (zeros > 0) seen_next = 1'b1;
                else ones++;
            end else if (ones >= 8) begin
                zeros++;
            end
            if (!seen_next) @(negedge clk);
        end
        check("gap_first_word_bits", ones, 8);
        check("gap_low_cycles", zeros, 2);
        wait_idle(1);
        check("gap_count", int'(mc_w[1]), 7);

        // Clear on the cycle bit2 of 8'h55 matches.
        do_reset();
        send_word(0, 8'h55);
        @(negedge clk);
        @(negedge clk);
        clear_w[0] = 1'b1;
        @(negedge clk);
        clear_w[0] = 1'b0;
        check("clear_on_match", int'(mc_w[0]), 0);
        @(negedge clk);
        @(negedge clk);
        check("count_after_clear", int'(mc_w[0]), 1);
        wait_idle(0);
        check("clear_word_count", int'(mc_w[0]), 2);

        // Reset while bit 4 is on the wire.
        do_reset();
        send_word(0, 8'h55);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #2 rstb = 1'b0;
        #1;
        check("rst_mid_enable", int'(enable_w[0]), 0);
        check("rst_mid_serial", int'(serial_w[0]), 0);
        check("rst_mid_count", int'(mc_w[0]), 0);
        check("rst_mid_ready", int'(in_ready[0]), 1);
        @(negedge clk);
        @(posedge clk);
        #2 rstb = 1'b1;
        @(negedge clk);
        ens = 0;
        repeat (20) begin
            @(negedge clk);
            if (enable_w[0]) ens++;
        end
        check("rst_mid_no_tx", ens, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
